// File: rtl/vend_sequencer.sv
// vend_sequencer: coin credit, round-robin A/B selection, dispense handshake and unit-by-unit change return
module vend_sequencer #(
  parameter int PRICE_A    = 2,
  parameter int PRICE_B    = 3,
  parameter int CREDIT_MAX = 15,
  parameter int TIMEOUT    = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [1:0] coin_value,
  input  logic       sel_a,
  input  logic       sel_b,
  input  logic       cancel,
  input  logic       disp_ready,
  output logic       disp_valid,
  output logic       disp_item,
  output logic       change_pulse,
  output logic       coin_reject,
  output logic       insufficient,
  output logic [3:0] credit,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;
  localparam logic [3:0] PA    = 4'(PRICE_A);
  localparam logic [3:0] PB    = 4'(PRICE_B);
  localparam logic [4:0] CMAX  = 5'(CREDIT_MAX);
  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);
  state_t state, state_n;
  logic [3:0] credit_n;
  logic [7:0] timer, timer_n;
  logic [4:0] sum;
  logic rr_last, rr_last_n, item_n, reject_n, insuf_n;
  logic coin, accept, sel_any, elig_a, elig_b, grant, grant_b;
  // next state: cancel beats selection beats coin; timer only runs while waiting idle in CREDIT
  always_comb begin
    state_n   = state;
    credit_n  = credit;
    timer_n   = 8'd0;
    rr_last_n = rr_last;
    item_n    = disp_item;
    insuf_n   = 1'b0;
    accept    = 1'b0;
    coin      = coin_valid && coin_value != 2'd0;
    sum       = {1'b0, credit} + {3'b000, coin_value};
    sel_any   = sel_a || sel_b;
    elig_a    = sel_a && credit >= PA;
    elig_b    = sel_b && credit >= PB;
    grant     = elig_a || elig_b;
    grant_b   = elig_b && (!elig_a || !rr_last);
    case (state)
      IDLE: begin
        accept = coin && sum <= CMAX;
        if (accept) begin
          credit_n = sum[3:0];
          state_n  = CREDIT;
        end
      end
      CREDIT: begin
        if (cancel) state_n = CHANGE;
        else if (grant) begin
          state_n   = DISPENSE;
          item_n    = grant_b;
          rr_last_n = grant_b;
        end else begin
          insuf_n = sel_any;
          accept  = coin && sum <= CMAX;
          if (accept) credit_n = sum[3:0];
          if (!sel_any && !accept) begin
            if (timer == TLAST) state_n = CHANGE;
            else timer_n = timer + 8'd1;
          end
        end
      end
      DISPENSE: begin
        if (disp_ready) begin
          credit_n = credit - (disp_item ? PB : PA);
          state_n  = credit_n != 4'd0 ? CHANGE : IDLE;
        end
      end
      CHANGE: begin
        credit_n = credit == 4'd0 ? 4'd0 : credit - 4'd1;
        state_n  = credit <= 4'd1 ? IDLE : CHANGE;
      end
    endcase
    reject_n = coin && !accept;
  end
  // state and registered outputs; reset aborts any sale or refund at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      credit       <= 4'd0;
      timer        <= 8'd0;
      rr_last      <= 1'b1;
      disp_item    <= 1'b0;
      disp_valid   <= 1'b0;
      change_pulse <= 1'b0;
      busy         <= 1'b0;
      coin_reject  <= 1'b0;
      insufficient <= 1'b0;
    end else begin
      state        <= state_n;
      credit       <= credit_n;
      timer        <= timer_n;
      rr_last      <= rr_last_n;
      disp_item    <= item_n;
      disp_valid   <= state_n == DISPENSE;
      change_pulse <= state_n == CHANGE;
      busy         <= state_n == DISPENSE || state_n == CHANGE;
      coin_reject  <= reject_n;
      insufficient <= insuf_n;
    end
  end
endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: directed scenarios plus random traffic checked every cycle against a transaction-level model
module tb_vend_sequencer;
  localparam int PA = 2, PB = 3, CMAX = 15, TO = 4;
  logic clk = 0, reset = 1;
  logic coin_valid = 0, sel_a = 0, sel_b = 0, cancel = 0, disp_ready = 0;
  logic [1:0] coin_value = 0;
  logic disp_valid, disp_item, change_pulse, coin_reject, insufficient, busy;
  logic [3:0] credit;
  int n_cmp = 0, n_bad = 0, n;

  vend_sequencer #(.PRICE_A(PA), .PRICE_B(PB), .CREDIT_MAX(CMAX), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_a(sel_a), .sel_b(sel_b), .cancel(cancel), .disp_ready(disp_ready),
    .disp_valid(disp_valid), .disp_item(disp_item), .change_pulse(change_pulse),
    .coin_reject(coin_reject), .insufficient(insufficient), .credit(credit), .busy(busy));

  always #5 clk = ~clk;

  // pend: -1 no sale pending, 0 item A, 1 item B; refund: returning change
  typedef struct packed {
    int credit; int pend; bit refund; int idle; bit last_b; bit rej; bit ins;
  } mst_t;
  localparam mst_t M0 = '{credit: 0, pend: -1, refund: 0, idle: 0, last_b: 1, rej: 0, ins: 0};
  mst_t m = M0;

  function automatic mst_t next_m(mst_t s, bit cv, int val, bit sa, bit sb, bit can, bit rdy);
    mst_t r = s;
    bit coin = cv && val != 0;
    bit acc = 0;
    bit ea = sa && s.credit >= PA;
    bit eb = sb && s.credit >= PB;
    r.idle = 0;
    r.ins = 0;
    if (s.pend >= 0) begin
      if (rdy) begin
        r.credit = s.credit - (s.pend == 1 ? PB : PA);
        r.pend = -1;
        r.refund = r.credit > 0;
      end
    end else if (s.refund) begin
      r.credit = s.credit - 1;
      r.refund = r.credit > 0;
    end else if (s.credit > 0 && can) r.refund = 1;
    else if (s.credit > 0 && (ea || eb)) begin
      r.pend = (ea && eb) ? (s.last_b ? 0 : 1) : (eb ? 1 : 0);
      r.last_b = r.pend == 1;
    end else begin
      r.ins = s.credit > 0 && (sa || sb);
      acc = coin && s.credit + val <= CMAX;
      if (acc) r.credit = s.credit + val;
      else if (s.credit > 0 && !(sa || sb)) begin
        r.idle = s.idle + 1;
        if (r.idle == TO) r.refund = 1;
      end
    end
    r.rej = coin && !acc;
    return r;
  endfunction

  always @(posedge clk or posedge reset)
    m <= reset ? M0 : next_m(m, coin_valid, int'(coin_value), sel_a, sel_b, cancel, disp_ready);

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (!reset) begin
    check("m_credit", int'(credit), m.credit);
    check("m_disp_valid", int'(disp_valid), int'(m.pend >= 0));
    if (m.pend >= 0) check("m_disp_item", int'(disp_item), m.pend);
    check("m_change_pulse", int'(change_pulse), int'(m.refund));
    check("m_busy", int'(busy), int'(m.pend >= 0 || m.refund));
    check("m_coin_reject", int'(coin_reject), int'(m.rej));
    check("m_insufficient", int'(insufficient), int'(m.ins));
  end

  task automatic clk1;
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(int v);
    coin_valid = 1;
    coin_value = 2'(v);
    clk1();
    coin_valid = 0;
    coin_value = 0;
  endtask

  task automatic drain(output int pulses);
    pulses = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      if (change_pulse) pulses++;
      clk1();
    end
    check("drain_done", int'(busy), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_credit", int'(credit), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_disp_valid", int'(disp_valid), 0);
    @(negedge clk) reset = 0;
    // purchase B with two 2-unit coins
    put_coin(2);
    put_coin(2);
    check("t1_credit4", int'(credit), 4);
    check("t1_model4", m.credit, 4);
    disp_ready = 1;
    sel_b = 1;
    clk1();
    sel_b = 0;
    check("t1_valid", int'(disp_valid), 1);
    check("t1_item", int'(disp_item), 1);
    clk1();
    check("t1_credit1", int'(credit), 1);
    check("t1_pulse", int'(change_pulse), 1);
    drain(n);
    check("t1_pulses", n, 1);
    disp_ready = 0;
    // overflow rejection then fill to the cap
    put_coin(3); put_coin(3); put_coin(3); put_coin(3); put_coin(1);
    check("t2_credit13", int'(credit), 13);
    put_coin(3);
    check("t2_reject", int'(coin_reject), 1);
    check("t2_hold13", int'(credit), 13);
    put_coin(2);
    check("t2_credit15", int'(credit), 15);
    check("t2_model15", m.credit, 15);
    cancel = 1;
    clk1();
    cancel = 0;
    drain(n);
    check("t2_pulses", n, 15);
    // round-robin on simultaneous requests
    disp_ready = 1;
    for (int k = 0; k < 3; k++) begin
      put_coin(3);
      put_coin(3);
      sel_a = 1;
      sel_b = 1;
      clk1();
      sel_a = 0;
      sel_b = 0;
      check("t3_rr_item", int'(disp_item), k == 1 ? 1 : 0);
      clk1();
      drain(n);
    end
    disp_ready = 0;
    // insufficient credit then cancel
    put_coin(1);
    sel_a = 1;
    clk1();
    sel_a = 0;
    check("t4_insufficient", int'(insufficient), 1);
    check("t4_not_busy", int'(busy), 0);
    cancel = 1;
    clk1();
    cancel = 0;
    check("t4_pulse", int'(change_pulse), 1);
    drain(n);
    check("t4_pulses", n, 1);
    check("t4_credit0", int'(credit), 0);
    // dispenser stalls while a coin arrives
    put_coin(3);
    put_coin(2);
    sel_a = 1;
    clk1();
    sel_a = 0;
    check("t5_valid", int'(disp_valid), 1);
    check("t5_item", int'(disp_item), 0);
    put_coin(1);
    check("t5_reject", int'(coin_reject), 1);
    check("t5_credit5", int'(credit), 5);
    repeat (3) clk1();
    check("t5_still_valid", int'(disp_valid), 1);
    disp_ready = 1;
    clk1();
    disp_ready = 0;
    check("t5_credit3", int'(credit), 3);
    check("t5_dropped", int'(disp_valid), 0);
    drain(n);
    check("t5_pulses", n, 3);
    // inactivity timeout
    put_coin(2);
    repeat (3) clk1();
    check("t6_waiting", int'(busy), 0);
    clk1();
    check("t6_timeout", int'(change_pulse), 1);
    drain(n);
    check("t6_pulses", n, 2);
    // asynchronous reset during change return
    put_coin(3);
    cancel = 1;
    clk1();
    cancel = 0;
    check("t7_credit3", int'(credit), 3);
    #2 reset = 1;
    #1;
    check("t7_credit0", int'(credit), 0);
    check("t7_pulse0", int'(change_pulse), 0);
    check("t7_busy0", int'(busy), 0);
    @(negedge clk) reset = 0;
    clk1();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      coin_valid = $urandom_range(0, 9) < 3;
      coin_value = coin_valid ? 2'($urandom_range(1, 3)) : 2'd0;
      sel_a = $urandom_range(0, 9) < 2;
      sel_b = $urandom_range(0, 9) < 2;
      cancel = $urandom_range(0, 39) == 0;
      disp_ready = 1'($urandom_range(0, 1));
      clk1();
    end
    coin_valid = 0; coin_value = 0; sel_a = 0; sel_b = 0; cancel = 0; disp_ready = 1;
    drain(n);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vend_sequencer.md
Name: vend_sequencer

Overview:
Transaction controller for the vending datapath. It accumulates coin credit, arbitrates product-select requests A/B with round-robin fairness, and holds a dispense request to the dispenser through a valid/ready handshake. After a sale, cancel or inactivity timeout it returns the remaining credit as one change pulse per credit unit. It sits between the coin/button front end and the dispenser and change-hopper drivers.

Parameters:
PRICE_A, 2, price of item A in credit units (1..15)
PRICE_B, 3, price of item B in credit units (1..15)
CREDIT_MAX, 15, maximum credit held (<=15)
TIMEOUT, 100, idle cycles in CREDIT before automatic refund (1..255)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
coin_valid  input  1  coin present this cycle
coin_value  input  2  coin value in units (0 is treated as no coin)
sel_a  input  1  request item A (level, sampled each cycle)
sel_b  input  1  request item B
cancel  input  1  refund request
disp_ready  input  1  dispenser accepts request
disp_valid  output  1  dispense request pending
disp_item  output  1  0 = A, 1 = B; stable while disp_valid
change_pulse  output  1  one pulse = one credit unit returned
coin_reject  output  1  1-cycle pulse: coin not accepted
insufficient  output  1  1-cycle pulse: selection refused for low credit
credit  output  4  current credit
busy  output  1  high in DISPENSE or CHANGE

Behaviour:
- Reset (async) values: state IDLE, credit 0, all outputs 0, rr_last = B (A wins the first tie), timer 0.
- States: IDLE (credit 0), CREDIT, DISPENSE, CHANGE. All outputs are registered.
- Coin accept (IDLE/CREDIT only):
  - Condition: coin_valid, coin_value != 0, and credit + coin_value <= CREDIT_MAX.
  - Effect: credit += value at the next edge; IDLE -> CREDIT.
  - Otherwise coin_reject = 1 on the next cycle and credit is unchanged.
  - Every coin_valid in DISPENSE/CHANGE is rejected.
- Selection (CREDIT only):
  - An item is eligible when its sel input is high and credit >= its price.
  - Both eligible: grant the item not served last (rr_last), then update rr_last.
  - One eligible: grant it.
  - Requested but none eligible: insufficient pulse, stay in CREDIT.
  - A grant at edge N gives disp_valid = 1 and disp_item set from cycle N+1; state DISPENSE.
- Priority in one cycle: cancel > selection > coin.
  - A coin arriving with a cancel or a grant is rejected.
  - Cancel in CREDIT -> CHANGE. Cancel in IDLE is ignored.
- DISPENSE:
  - disp_valid and disp_item are held until disp_valid && disp_ready.
  - On that edge credit -= price, disp_valid drops, and the state moves to CHANGE if the remainder > 0, else IDLE.
  - cancel and sel are ignored while in DISPENSE.
- CHANGE:
  - change_pulse = 1 each cycle; credit decrements by 1 on each pulse edge.
  - Credit k produces exactly k consecutive pulses, then IDLE with change_pulse = 0.
- Timeout:
  - The timer clears on any accepted coin, selection attempt or state entry.
  - It increments in CREDIT only; reaching TIMEOUT -> CHANGE.
- Credit never exceeds CREDIT_MAX and never underflows; price > credit can never be granted.
- Reset mid-DISPENSE or mid-CHANGE aborts immediately. Credit is lost and disp_valid/change_pulse drop asynchronously.
- busy = 1 exactly when the state is DISPENSE or CHANGE.

Test Plan:
- Coins 2, 2 then sel_b; disp_ready high -> credit 4; disp_valid and disp_item = 1 the cycle after the grant; credit 1; one change_pulse; back to IDLE.
- Credit 13, then coin 3 -> coin_reject pulse, credit stays 13; then coin 2 -> credit 15.
- Credit 6, sel_a and sel_b both high in three separate purchases -> grants A, B, A (round-robin, A first after reset).
- Credit 1, sel_a -> insufficient pulse, state CREDIT; then cancel -> 1 change_pulse, IDLE.
- Credit 5, hold disp_ready low for 4 cycles after a sel_a grant, coin inserted meanwhile -> disp_valid stays high, coin_reject, credit 5; on ready, credit 3 and 3 change pulses.
- TIMEOUT = 4, credit 2, no activity -> CHANGE entered after 4 cycles, 2 pulses.
- Reset asserted during CHANGE at credit 3 -> credit 0 and change_pulse 0 immediately.
